// File: rtl/uart_tx_pkg.sv
// Shared types, constants and helpers for the UART transmit frame sequencer.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Line mux select codes: what the output bit mux puts on the TX line.
    localparam logic [1:0] MUX_START = 2'd0;  // start bit, constant 0
    localparam logic [1:0] MUX_DATA  = 2'd1;  // current serializer bit
    localparam logic [1:0] MUX_PAR   = 2'd2;  // parity bit
    localparam logic [1:0] MUX_IDLE  = 2'd3;  // idle / stop, constant 1

    // Counter width for a count of w values, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

    // Line mux select that belongs to each state.
    function automatic logic [1:0] mux_for(input state_t s);
        case (s)
            START:   return MUX_START;
            DATA:    return MUX_DATA;
            PARITY:  return MUX_PAR;
            default: return MUX_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_cnt.sv
// Saturating up-counter with synchronous clear, enable and terminal-count flag.
// Counts 0..MAX-1 and holds at MAX-1 so it can never wrap mid-frame.
module uart_bit_cnt #(
    parameter int WIDTH = 3,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

    assign tc = (cnt == LAST);

    // Count register: reset/clear to zero, otherwise advance until the last value.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: START, DATA, optional PARITY, STOP.
// Latches the frame configuration on acceptance and drives the serializer
// enable/index, the line mux select and the BUSY gate for the datapath.
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int IN_DATA_WIDTH = 8,
    parameter int STOP_BITS     = 1
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic                                    Data_Valid,
    input  logic                                    PAR_EN,
    input  logic                                    PAR_TYP,
    output logic                                    Load,
    output logic                                    BUSY,
    output logic                                    Ser_En,
    output logic [cnt_width(IN_DATA_WIDTH)-1:0]     Ser_Idx,
    output logic [1:0]                              Mux_Sel,
    output logic                                    Par_En_L,
    output logic                                    Par_Typ_L
);

    localparam int IDX_W  = cnt_width(IN_DATA_WIDTH);
    localparam int STOP_W = cnt_width(STOP_BITS);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   data_cnt;
    logic               data_tc;
    logic [STOP_W-1:0]  stop_cnt;
    logic               stop_tc;

    // Requests are only taken in IDLE; anything arriving while busy is dropped.
    assign Load = Data_Valid && (state == IDLE);

    // Data-bit counter: cleared in START, advances once per DATA cycle.
    uart_bit_cnt #(
        .WIDTH (IDX_W),
        .MAX   (IN_DATA_WIDTH)
    ) u_data_cnt (
        .clk (CLK),
        .rst (RST),
        .clr (state == START),
        .en  (state == DATA),
        .cnt (data_cnt),
        .tc  (data_tc)
    );

    // Stop-bit counter: cleared on the last data bit, advances in STOP.
    uart_bit_cnt #(
        .WIDTH (STOP_W),
        .MAX   (STOP_BITS)
    ) u_stop_cnt (
        .clk (CLK),
        .rst (RST),
        .clr ((state == DATA) && data_tc),
        .en  (state == STOP),
        .cnt (stop_cnt),
        .tc  (stop_tc)
    );

    // Next-state decode; illegal encodings fall back to IDLE.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned and infers a latch.
        state_next = state;
        case (state)
            IDLE:    if (Data_Valid) state_next = START;
            START:   state_next = DATA;
            DATA:    if (data_tc) state_next = Par_En_L ? PARITY : STOP;
            PARITY:  state_next = STOP;
            STOP:    if (stop_tc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, frame configuration latch and registered Moore outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            Par_En_L  <= 1'b0;
            Par_Typ_L <= 1'b0;
            BUSY      <= 1'b0;
            Ser_En    <= 1'b0;
            Mux_Sel   <= MUX_IDLE;
        end else begin
            state   <= state_next;
            BUSY    <= (state_next != IDLE);
            Ser_En  <= (state_next == DATA);
            Mux_Sel <= mux_for(state_next);
            if (Load) begin
                Par_En_L  <= PAR_EN;
                Par_Typ_L <= PAR_TYP;
            end
        end
    end

    // Index only meaningful while shifting; held at zero otherwise.
    assign Ser_Idx = Ser_En ? data_cnt : '0;

endmodule
